// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory handshakes,
// wait-state timeout and a trap path.
module mcpu_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       nCondition,
  input  logic       imem_rdy,
  input  logic       dmem_rdy,
  output logic       imem_req,
  output logic       dmem_req,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [1:0] npc_sel,
  output logic [1:0] ALUOp,
  output logic [1:0] ExtOp,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       write_30,
  output logic       pcwr,
  output logic       irwr,
  output logic       islb,
  output logic       issb,
  output logic       trap,
  output logic       trap_sel,
  output logic [1:0] cause
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cause_q;
  logic [1:0]       cause_n;
  logic             to_hit;

  logic rtype;
  logic i_addu, i_subu, i_slt, i_jr;
  logic i_ori, i_lui, i_addi, i_addiu;
  logic i_lw, i_sw, i_lb, i_sb;
  logic i_beq, i_j, i_jal, i_bltzal;
  logic is_load, is_store, is_mem;
  logic is_alu, is_br, is_jmp;

  assign rtype    = (opcode == 6'b000000);
  assign i_addu   = rtype & (funct == 6'b100001);
  assign i_subu   = rtype & (funct == 6'b100011);
  assign i_slt    = rtype & (funct == 6'b101010);
  assign i_jr     = rtype & (funct == 6'b001000);
  assign i_ori    = (opcode == 6'b001101);
  assign i_lui    = (opcode == 6'b001111);
  assign i_addi   = (opcode == 6'b001000);
  assign i_addiu  = (opcode == 6'b001001);
  assign i_lw     = (opcode == 6'b100011);
  assign i_sw     = (opcode == 6'b101011);
  assign i_lb     = (opcode == 6'b100000);
  assign i_sb     = (opcode == 6'b101000);
  assign i_beq    = (opcode == 6'b000100);
  assign i_j      = (opcode == 6'b000010);
  assign i_jal    = (opcode == 6'b000011);
  assign i_bltzal = (opcode == 6'b000001);

  assign is_load  = i_lw | i_lb;
  assign is_store = i_sw | i_sb;
  assign is_mem   = is_load | is_store;
  assign is_alu   = i_addu | i_subu | i_slt | i_ori
                  | i_lui | i_addi | i_addiu;
  assign is_br    = i_beq | i_jr | i_bltzal;
  assign is_jmp   = i_j | i_jal;

  assign to_hit = TO_EN && (cnt == LIMIT);

  // State, wait counter and trap cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cnt     <= '0;
      cause_q <= 2'b00;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
      if (state_n == state) cnt <= cnt + 1'b1;
      else                  cnt <= '0;
    end
  end

  // Next-state logic; only wait states loop on themselves
  always_comb begin
    state_n = state;
    cause_n = cause_q;
    case (state)
      S_FETCH: begin
        if (imem_rdy) state_n = S_DECODE;
        else if (to_hit) begin
          state_n = S_TRAP;
          cause_n = 2'b10;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_mem: state_n = S_MEMADR;
          is_alu: state_n = S_EXEC;
          is_br:  state_n = S_BRANCH;
          is_jmp: state_n = S_JUMP;
          default: begin
            state_n = S_TRAP;
            cause_n = 2'b01;
          end
        endcase
      end
      S_MEMADR: state_n = is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (dmem_rdy) state_n = S_MEMWB;
        else if (to_hit) begin
          state_n = S_TRAP;
          cause_n = 2'b11;
        end
      end
      S_MEMWR: begin
        if (dmem_rdy) state_n = S_FETCH;
        else if (to_hit) begin
          state_n = S_TRAP;
          cause_n = 2'b11;
        end
      end
      S_EXEC:   state_n = S_ALUWB;
      S_MEMWB:  state_n = S_FETCH;
      S_ALUWB:  state_n = S_FETCH;
      S_BRANCH: state_n = S_FETCH;
      S_JUMP:   state_n = S_FETCH;
      S_TRAP:   state_n = S_FETCH;
      default:  state_n = S_FETCH;
    endcase
  end

  // Datapath controls; writes are squashed in a reset cycle
  always_comb begin
    imem_req = (state == S_FETCH);
    irwr     = (state == S_FETCH) & imem_rdy;
    dmem_req = (state == S_MEMRD) | (state == S_MEMWR);
    MemWrite = (state == S_MEMWR) & dmem_rdy & ~rst;
    trap     = (state == S_TRAP);
    trap_sel = (state == S_TRAP);
    cause    = cause_q;

    RegWrite = ~rst & (
        ((state == S_ALUWB) & is_alu)
      | ((state == S_MEMWB) & is_load)
      | ((state == S_JUMP) & i_jal)
      | ((state == S_BRANCH) & i_bltzal & nCondition));

    pcwr = irwr
      | (state == S_JUMP)
      | (state == S_TRAP)
      | ((state == S_BRANCH) & ((i_beq & zero) | i_jr
          | (i_bltzal & nCondition)));

    npc_sel = 2'b00;
    if (state != S_FETCH) begin
      unique case (1'b1)
        i_beq | i_bltzal: npc_sel = 2'b01;
        i_j | i_jal:      npc_sel = 2'b10;
        i_jr:             npc_sel = 2'b11;
        default:          npc_sel = 2'b00;
      endcase
    end

    RegDst = 2'b00;
    if (i_addu | i_subu | i_slt)  RegDst = 2'b01;
    else if (i_jal | i_bltzal)    RegDst = 2'b10;

    MemToReg = 2'b00;
    if (is_load)                  MemToReg = 2'b01;
    else if (i_jal | i_bltzal)    MemToReg = 2'b10;

    ALUOp = 2'b00;
    unique case (1'b1)
      i_subu | i_beq: ALUOp = 2'b01;
      i_ori | i_lui:  ALUOp = 2'b10;
      i_slt:          ALUOp = 2'b11;
      default:        ALUOp = 2'b00;
    endcase

    ExtOp = 2'b00;
    if (i_lui) ExtOp = 2'b10;
    else if (i_addi | i_addiu | is_mem | i_beq) ExtOp = 2'b01;

    ALUSrc   = i_ori | i_lui | i_addi | i_addiu | is_mem;
    write_30 = i_addi;
    islb     = i_lb;
    issb     = i_sb;
  end

endmodule
